// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter feeding one registered request to the SDRAM controller.
// Ports: clock/reset (async active-low), m_* master side, sdram_* controller side.
module sdram_arbiter #(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = 26
) (
   input  logic                          clock,
   input  logic                          reset,
   input  logic [NUM_MASTERS-1:0]        m_req,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS-1:0]        m_write,
   input  logic [NUM_MASTERS*4-1:0]      m_byte_enable,
   input  logic [NUM_MASTERS*32-1:0]     m_wdata,
   output logic [NUM_MASTERS-1:0]        m_ack,
   output logic [31:0]                   m_rdata,
   output logic [NUM_MASTERS-1:0]        m_rdvalid,
   output logic [NUM_MASTERS-1:0]        sdram_req,
   output logic [ADDR_W-1:0]             sdram_addr,
   output logic                          sdram_write,
   output logic [3:0]                    sdram_byte_enable,
   output logic [31:0]                   sdram_wdata,
   input  logic                          sdram_ack,
   input  logic [31:0]                   sdram_rdata,
   input  logic [NUM_MASTERS-1:0]        sdram_rdvalid
);

   localparam int GW = $clog2(NUM_MASTERS);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] req_q, req_d;
   logic [NUM_MASTERS-1:0] ack_q, ack_d;
   logic [ADDR_W-1:0]      addr_q, addr_d;
   logic                   write_q, write_d;
   logic [3:0]             be_q, be_d;
   logic [31:0]            wdata_q, wdata_d;
   logic [GW-1:0]          gidx_q, gidx_d;
   logic [GW-1:0]          last_q, last_d;
   logic [31:0]            rdata_q, rdata_d;
   logic [NUM_MASTERS-1:0] rdv_q, rdv_d;

   logic [NUM_MASTERS-1:0] eligible;
   logic [GW-1:0]          pick_idx;
   logic                   found;

   // A master acked this cycle is still holding m_req; don't re-grant it.
   assign eligible = m_req & ~ack_q;

   // First eligible master scanning upward from last_grant+1, wrapping.
   always_comb begin
      pick_idx = '0;
      found    = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         if (!found && eligible[(int'(last_q) + k) % NUM_MASTERS]) begin
            found    = 1'b1;
            pick_idx = GW'((int'(last_q) + k) % NUM_MASTERS);
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         req_q   <= '0;
         ack_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         gidx_q  <= '0;
         last_q  <= GW'(NUM_MASTERS - 1);
         rdata_q <= '0;
         rdv_q   <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         ack_q   <= ack_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         gidx_q  <= gidx_d;
         last_q  <= last_d;
         rdata_q <= rdata_d;
         rdv_q   <= rdv_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (found) state_d = BUSY;
         BUSY:    if (sdram_ack) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_d   = req_q;
      ack_d   = '0;
      addr_d  = addr_q;
      write_d = write_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      gidx_d  = gidx_q;
      last_d  = last_q;
      // Read return is a plain 1-cycle pipe, independent of the FSM.
      rdata_d = sdram_rdata;
      rdv_d   = sdram_rdvalid;
      if (state_q == IDLE && found) begin
         req_d   = NUM_MASTERS'(1) << pick_idx;
         addr_d  = m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
         write_d = m_write[pick_idx];
         be_d    = m_byte_enable[int'(pick_idx)*4 +: 4];
         wdata_d = m_wdata[int'(pick_idx)*32 +: 32];
         gidx_d  = pick_idx;
      end else if (state_q == BUSY && sdram_ack) begin
         req_d  = '0;
         ack_d  = req_q;
         last_d = gidx_q;
      end
   end

   assign m_ack             = ack_q;
   assign m_rdata           = rdata_q;
   assign m_rdvalid         = rdv_q;
   assign sdram_req         = req_q;
   assign sdram_addr        = addr_q;
   assign sdram_write       = write_q;
   assign sdram_byte_enable = be_q;
   assign sdram_wdata       = wdata_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed + randomized bench for sdram_arbiter.
// Reference model tracks grant/ack/read-return behaviour per clock edge.
module tb_sdram_arbiter;

   localparam int N  = 3;
   localparam int AW = 26;

   logic            clock = 1'b0;
   logic            reset;
   logic [N-1:0]    m_req;
   logic [N*AW-1:0] m_addr;
   logic [N-1:0]    m_write;
   logic [N*4-1:0]  m_byte_enable;
   logic [N*32-1:0] m_wdata;
   logic [N-1:0]    m_ack;
   logic [31:0]     m_rdata;
   logic [N-1:0]    m_rdvalid;
   logic [N-1:0]    sdram_req;
   logic [AW-1:0]   sdram_addr;
   logic            sdram_write;
   logic [3:0]      sdram_byte_enable;
   logic [31:0]     sdram_wdata;
   logic            sdram_ack;
   logic [31:0]     sdram_rdata;
   logic [N-1:0]    sdram_rdvalid;

   sdram_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW)) dut (
      .clock(clock), .reset(reset),
      .m_req(m_req), .m_addr(m_addr), .m_write(m_write),
      .m_byte_enable(m_byte_enable), .m_wdata(m_wdata),
      .m_ack(m_ack), .m_rdata(m_rdata), .m_rdvalid(m_rdvalid),
      .sdram_req(sdram_req), .sdram_addr(sdram_addr),
      .sdram_write(sdram_write), .sdram_byte_enable(sdram_byte_enable),
      .sdram_wdata(sdram_wdata), .sdram_ack(sdram_ack),
      .sdram_rdata(sdram_rdata), .sdram_rdvalid(sdram_rdvalid)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit          busy;
   int          gidx;
   int          last;
   logic [N-1:0] e_req, e_ack, e_rdv;
   logic [AW-1:0] e_addr;
   logic        e_write;
   logic [3:0]  e_be;
   logic [31:0] e_wdata, e_rdata;
   logic [N-1:0] prev_ack;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      busy = 0; gidx = 0; last = N - 1;
      e_req = '0; e_ack = '0; e_rdv = '0;
      e_addr = '0; e_write = 0; e_be = '0;
      e_wdata = '0; e_rdata = '0;
   endtask

   task automatic model_edge();
      logic [N-1:0] elig;
      logic [N-1:0] nack;
      nack = '0;
      if (!busy) begin
         elig = m_req & ~e_ack;
         if (elig != 0) begin
            for (int k = 1; k <= N; k++) begin
               if (elig[(last + k) % N]) begin
                  gidx = (last + k) % N;
                  break;
               end
            end
            busy    = 1;
            e_req   = N'(1) << gidx;
            e_addr  = m_addr[gidx*AW +: AW];
            e_write = m_write[gidx];
            e_be    = m_byte_enable[gidx*4 +: 4];
            e_wdata = m_wdata[gidx*32 +: 32];
         end
      end else if (sdram_ack) begin
         e_req = '0;
         nack  = N'(1) << gidx;
         last  = gidx;
         busy  = 0;
      end
      e_ack   = nack;
      e_rdata = sdram_rdata;
      e_rdv   = sdram_rdvalid;
   endtask

   task automatic check_all();
      chk("sdram_req", 32'(sdram_req), 32'(e_req));
      chk("m_ack", 32'(m_ack), 32'(e_ack));
      chk("sdram_addr", 32'(sdram_addr), 32'(e_addr));
      chk("sdram_write", 32'(sdram_write), 32'(e_write));
      chk("sdram_be", 32'(sdram_byte_enable), 32'(e_be));
      chk("sdram_wdata", sdram_wdata, e_wdata);
      chk("m_rdata", m_rdata, e_rdata);
      chk("m_rdvalid", 32'(m_rdvalid), 32'(e_rdv));
      chk("ack_onehot0", 32'($onehot0(m_ack)), 32'd1);
      chk("ack_no_repeat", 32'(|(m_ack & prev_ack)), 32'd0);
      prev_ack = m_ack;
   endtask

   task automatic step();
      @(posedge clock);
      model_edge();
      @(negedge clock);
      check_all();
   endtask

   task automatic do_reset();
      m_req = '0; m_addr = '0; m_write = '0;
      m_byte_enable = '0; m_wdata = '0;
      sdram_ack = 0; sdram_rdata = '0; sdram_rdvalid = '0;
      reset = 0;
      model_reset();
      prev_ack = '0;
      repeat (2) @(negedge clock);
      check_all();
      reset = 1;
   endtask

   initial begin
      logic [N-1:0] ord2 [4];
      logic [N-1:0] ord3 [3];
      int r;
      ord2 = '{3'b001, 3'b010, 3'b100, 3'b001};
      ord3 = '{3'b010, 3'b100, 3'b010};

      // 1: single read from master 0, ack, then tagged read data
      do_reset();
      m_req = 3'b001;
      m_addr[0 +: AW] = 26'h0000100;
      step();
      chk("t1_grant", 32'(sdram_req), 32'h1);
      chk("t1_addr", 32'(sdram_addr), 32'h100);
      step();
      step();
      sdram_ack = 1;
      step();
      chk("t1_ack", 32'(m_ack), 32'h1);
      m_req = '0;
      sdram_ack = 0;
      sdram_rdvalid = 3'b001;
      sdram_rdata = 32'hDEADBEEF;
      step();
      chk("t1_rdvalid", 32'(m_rdvalid), 32'h1);
      chk("t1_rdata", m_rdata, 32'hDEADBEEF);
      sdram_rdvalid = '0;
      step();
      chk("t1_rdvalid_off", 32'(m_rdvalid), 32'h0);

      // 2: all three requesting, round-robin order
      do_reset();
      m_req = 3'b111;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t2_grant", 32'(sdram_req), 32'(ord2[i]));
         step();
         sdram_ack = 1;
         step();
         sdram_ack = 0;
      end

      // 3: masters 1 and 2 alternate
      do_reset();
      m_req = 3'b110;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_grant", 32'(sdram_req), 32'(ord3[i]));
         sdram_ack = 1;
         step();
         sdram_ack = 0;
      end

      // 4: master 2 write with delayed ack
      do_reset();
      m_req = 3'b100;
      m_write = 3'b100;
      m_addr[2*AW +: AW] = 26'h2ABCDEF;
      m_byte_enable[8 +: 4] = 4'b0101;
      m_wdata[64 +: 32] = 32'h12345678;
      step();
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_req", 32'(sdram_req), 32'h4);
         chk("t4_write", 32'(sdram_write), 32'h1);
         chk("t4_be", 32'(sdram_byte_enable), 32'h5);
         chk("t4_wdata", sdram_wdata, 32'h12345678);
         chk("t4_addr", 32'(sdram_addr), 32'h2ABCDEF);
      end
      sdram_ack = 1;
      step();
      chk("t4_ack", 32'(m_ack), 32'h4);
      sdram_ack = 0;
      m_req = '0;
      step();

      // 5: asynchronous reset while busy
      do_reset();
      m_req = 3'b111;
      sdram_rdvalid = 3'b010;
      sdram_rdata = 32'hCAFEF00D;
      step();
      step();
      #2 reset = 0;
      model_reset();
      #1;
      check_all();
      chk("t5_req_clr", 32'(sdram_req), 32'h0);
      chk("t5_rdv_clr", 32'(m_rdvalid), 32'h0);
      chk("t5_rdata_clr", m_rdata, 32'h0);
      sdram_rdvalid = '0;
      @(negedge clock);
      reset = 1;
      step();
      chk("t5_first", 32'(sdram_req), 32'h1);

      // 6: ack while idle is ignored
      do_reset();
      sdram_ack = 1;
      step();
      step();
      chk("t6_ack", 32'(m_ack), 32'h0);
      chk("t6_req", 32'(sdram_req), 32'h0);
      sdram_ack = 0;

      // random traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!m_req[i] || m_ack[i]) begin
               m_req[i] = 1'($urandom % 2);
               m_write[i] = 1'($urandom % 2);
               m_addr[i*AW +: AW] = AW'($urandom);
               m_byte_enable[i*4 +: 4] = 4'($urandom);
               m_wdata[i*32 +: 32] = $urandom;
            end
         end
         sdram_ack = ($urandom % 3 == 0);
         r = int'($urandom % 4);
         sdram_rdvalid = (r == 3) ? 3'b000 : N'(1) << r;
         sdram_rdata = $urandom;
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
